// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC parallel-bus sequencer.
// Phase states, default timings, requester ids and RTC register addresses.
package rtc_bus_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_A_SETUP,
    ST_A_STROBE,
    ST_A_HOLD,
    ST_GAP,
    ST_D_SETUP,
    ST_D_STROBE,
    ST_D_HOLD,
    ST_DONE
  } state_e;

  localparam int DEF_SETUP_CYC  = 2;
  localparam int DEF_STROBE_CYC = 4;
  localparam int DEF_HOLD_CYC   = 2;
  localparam int DEF_GAP_CYC    = 2;

  localparam logic SCAN_PORT = 1'b0;
  localparam logic USER_PORT = 1'b1;

  localparam logic [7:0] REG_SECONDS = 8'h21;
  localparam logic [7:0] REG_MINUTES = 8'h22;
  localparam logic [7:0] REG_HOURS   = 8'h23;
  localparam logic [7:0] REG_COMMAND = 8'hF0;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  function automatic logic is_timed(input state_e s);
    return (s != ST_IDLE) && (s != ST_DONE);
  endfunction

endpackage

// File: rtl/rtc_bus_sequencer_timer.sv
// Loadable down-counter that times each bus phase; expire pulses on the
// last cycle of the loaded duration (load value is duration minus one).
module rtc_phase_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expire
);

  logic [WIDTH-1:0] count_q;
  logic             active_q;

  assign expire = active_q && (count_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      active_q <= 1'b0;
    end else if (load) begin
      count_q  <= load_val;
      active_q <= 1'b1;
    end else if (expire) begin
      active_q <= 1'b0;
    end else if (active_q) begin
      count_q  <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Arbitrates two requesters onto the RTC bus and sequences one address
// cycle plus one data cycle per transaction; all pins are registered.
module rtc_bus_sequencer
  import rtc_bus_pkg::*;
#(
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int STROBE_CYC = DEF_STROBE_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC,
  parameter int GAP_CYC    = DEF_GAP_CYC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_valid,
  input  logic [1:0] req_we,
  input  logic [7:0] req_addr0,
  input  logic [7:0] req_addr1,
  input  logic [7:0] req_wdata0,
  input  logic [7:0] req_wdata1,
  output logic [1:0] req_ack,
  output logic       done,
  output logic       done_id,
  output logic [7:0] rdata,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  input  logic [7:0] bus_in
);

  localparam int MAX_CYC = max4(SETUP_CYC, STROBE_CYC, HOLD_CYC, GAP_CYC);
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  state_e        state_q, state_d;
  logic          ptr_q, id_q, we_q;
  logic [7:0]    addr_q, wdata_q;
  logic [1:0]    req_ack_q;
  logic          done_q, done_id_q;
  logic [7:0]    rdata_q, bus_out_q;
  logic          cs_n_q, rd_n_q, wr_n_q, ad_q, bus_oe_q;

  logic          expire, timer_load, ack_any, grant, gnt_id;
  logic          addr_ph_d, data_ph_d;
  logic [TW-1:0] load_val;

  assign ack_any = |req_ack_q;
  // A grant is taken in an idle cycle with no ack outstanding, or while
  // leaving DONE so a waiting request is acked in the following IDLE.
  assign grant  = (((state_q == ST_IDLE) && !ack_any) || (state_q == ST_DONE)) && (|req_valid);
  assign gnt_id = (req_valid == 2'b11) ? ptr_q : req_valid[1];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (ack_any) state_d = ST_A_SETUP;
      ST_A_SETUP:  if (expire)  state_d = ST_A_STROBE;
      ST_A_STROBE: if (expire)  state_d = ST_A_HOLD;
      ST_A_HOLD:   if (expire)  state_d = ST_GAP;
      ST_GAP:      if (expire)  state_d = ST_D_SETUP;
      ST_D_SETUP:  if (expire)  state_d = ST_D_STROBE;
      ST_D_STROBE: if (expire)  state_d = ST_D_HOLD;
      ST_D_HOLD:   if (expire)  state_d = ST_DONE;
      ST_DONE:                  state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    load_val = '0;
    case (state_d)
      ST_A_SETUP, ST_D_SETUP:   load_val = TW'(SETUP_CYC - 1);
      ST_A_STROBE, ST_D_STROBE: load_val = TW'(STROBE_CYC - 1);
      ST_A_HOLD, ST_D_HOLD:     load_val = TW'(HOLD_CYC - 1);
      ST_GAP:                   load_val = TW'(GAP_CYC - 1);
      default:                  load_val = '0;
    endcase
  end

  assign timer_load = (state_d != state_q) && is_timed(state_d);
  assign addr_ph_d  = (state_d == ST_A_SETUP) || (state_d == ST_A_STROBE) || (state_d == ST_A_HOLD);
  assign data_ph_d  = (state_d == ST_D_SETUP) || (state_d == ST_D_STROBE) || (state_d == ST_D_HOLD);

  rtc_phase_timer #(.WIDTH(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (load_val),
    .expire   (expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= SCAN_PORT;
      id_q      <= SCAN_PORT;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      req_ack_q <= '0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      rdata_q   <= '0;
      cs_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      ad_q      <= 1'b1;
      bus_oe_q  <= 1'b0;
      bus_out_q <= '0;
    end else begin
      state_q   <= state_d;
      req_ack_q <= '0;
      if (grant) begin
        req_ack_q <= gnt_id ? 2'b10 : 2'b01;
        id_q      <= gnt_id;
        we_q      <= req_we[gnt_id];
        addr_q    <= gnt_id ? req_addr1 : req_addr0;
        wdata_q   <= gnt_id ? req_wdata1 : req_wdata0;
        ptr_q     <= ~gnt_id;
      end
      // Pins follow the state being entered so they switch with it.
      cs_n_q    <= !(addr_ph_d || data_ph_d);
      ad_q      <= !addr_ph_d;
      bus_oe_q  <= addr_ph_d || (data_ph_d && we_q);
      bus_out_q <= addr_ph_d ? addr_q : ((data_ph_d && we_q) ? wdata_q : 8'h00);
      wr_n_q    <= !((state_d == ST_A_STROBE) || ((state_d == ST_D_STROBE) && we_q));
      rd_n_q    <= !((state_d == ST_D_STROBE) && !we_q);
      done_q    <= (state_d == ST_DONE);
      if (state_d == ST_DONE) done_id_q <= id_q;
      if ((state_q == ST_D_STROBE) && expire && !we_q) rdata_q <= bus_in;
    end
  end

  assign req_ack = req_ack_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign rdata   = rdata_q;
  assign cs_n    = cs_n_q;
  assign rd_n    = rd_n_q;
  assign wr_n    = wr_n_q;
  assign ad      = ad_q;
  assign bus_oe  = bus_oe_q;
  assign bus_out = bus_out_q;

endmodule

// File: doc/rtc_bus_sequencer.md
Name: rtc_bus_sequencer

Overview:
Transaction-level controller for the parallel RTC bus (multiplexed address/data, strobes CS/RD/WR/A-D). Two requesters share the bus: port 0 is the periodic time-scan reader and port 1 is the user/config writer. A round-robin arbiter grants one request at a time. A phase state machine then runs one address cycle and one data cycle with programmable setup, strobe, hold and gap lengths. Sits between the clock/alarm logic and the RTC pins.

Parameters:
SETUP_CYC, 2, cycles of CS-low before each strobe (>=1)
STROBE_CYC, 4, cycles strobe held low (>=1)
HOLD_CYC, 2, cycles of CS-low after strobe release (>=1)
GAP_CYC, 2, cycles of CS-high between address and data cycles (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high; clock clk
req_valid  in  2  per-port request (bit0 = port 0, bit1 = port 1)
req_we  in  2  per-port 1 = write, 0 = read
req_addr0, req_addr1  in  8 each  RTC register address
req_wdata0, req_wdata1  in  8 each  write data
req_ack  out  2  one-cycle grant pulse; port must drop or change its request after ack
done  out  1  one-cycle completion pulse
done_id  out  1  port that completed
rdata  out  8  read result, valid when done=1 for a read; held until the next read
cs_n, rd_n, wr_n  out  1 each  RTC strobes, active low
ad  out  1  0 = address phase, 1 = data phase
bus_out  out  8  value driven onto the AD bus
bus_oe  out  1  tri-state enable for bus_out
bus_in  in  8  AD bus read-back

Behaviour:
- Reset values: cs_n=rd_n=wr_n=1, ad=1, bus_oe=0, bus_out=0, req_ack=0, done=0, done_id=0, rdata=0. Arbiter pointer favours port 0. State = IDLE.
- All pin outputs are registered and decoded from next-state, so pin levels change on the same edge as the state. No combinational path from inputs to pins.
- States: IDLE, A_SETUP, A_STROBE, A_HOLD, GAP, D_SETUP, D_STROBE, D_HOLD, DONE. Each timed state lasts its parameter count, measured by a down-counter loaded on entry.
- IDLE: if any req_valid is set, grant a port, pulse its req_ack and latch we/addr/wdata and the id. Go to A_SETUP on the next cycle.
- Arbitration: with a single requester, grant it. With both requesting, grant the port not served last, then toggle the pointer.
- Address cycle (A_SETUP, A_STROBE, A_HOLD):
  - Throughout: cs_n=0, ad=0, bus_oe=1, bus_out=addr.
  - wr_n=0 only in A_STROBE.
- GAP: cs_n=1, bus_oe=0, ad=1, all strobes high.
- Data cycle (D_SETUP, D_STROBE, D_HOLD): cs_n=0, ad=1.
  - Write: bus_oe=1, bus_out=wdata, wr_n=0 in D_STROBE.
  - Read: bus_oe=0, rd_n=0 in D_STROBE. bus_in is captured into rdata on the last D_STROBE cycle.
- DONE: one cycle; all pins idle; done=1, done_id=latched id. Then IDLE.
- Timing: ack-to-done latency is 2*(SETUP+STROBE+HOLD)+GAP+1 cycles (19 with defaults).
- Spacing: minimum spacing between consecutive transactions is one IDLE cycle. Back-to-back requests are granted in the IDLE that follows DONE.
- Requests arriving while busy are not acked and are not lost; they are sampled again in IDLE.
- rd_n and wr_n are never low simultaneously. Neither strobe is ever low while cs_n=1.
- Reset mid-transaction: pins return to idle on the next edge; the transaction is dropped with no done; the pointer is reset.

Decomposition:
- Package rtc_bus_pkg holds:
  - the state enum;
  - default timing constants;
  - the port-id constants SCAN_PORT=0 and USER_PORT=1;
  - the RTC register address constants (seconds 0x21, minutes 0x22, hours 0x23, command 0xF0).
- Sub-module rtc_phase_timer: loadable down-counter with a load input and a 1-cycle expire output, sized for max(SETUP,STROBE,HOLD,GAP).

Test Plan:
- Port 1 write, addr 0x21, wdata 0x59 -> bus_out=0x21 with ad=0 and wr_n low for 4 cycles; then ad=1, bus_out=0x59, wr_n low for 4 cycles; done=1, done_id=1 exactly 19 cycles after ack.
- Port 0 read, addr 0x22, bus_in=0x37 during D_STROBE -> rd_n low 4 cycles, bus_oe=0 in data phase, rdata=0x37, done_id=0.
- Both ports request continuously -> acks alternate 0,1,0,1; each done_id matches the prior ack; no grant while busy.
- reset asserted in D_STROBE -> next edge cs_n=rd_n=wr_n=1, bus_oe=0; no done; port 0 granted first afterward.
- Parameters SETUP=1, STROBE=1, HOLD=1, GAP=1 -> latency 8 cycles; strobe-overlap and CS-envelope assertions pass.
- Request held during an active transaction -> no req_ack until the IDLE after DONE, then acked within 1 cycle.
